// File: rtl/stack_render_if.sv
// Block-position and pixel-stream bundle between game logic, VGA timing and the stack renderer.
// Latency: none (wires only).
// Backpressure: none; the pixel stream is free-running and place/clear are single-cycle strobes.
interface stack_render_if;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [9:0] height;
    logic       place;
    logic       clear;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       video_on;
    logic [7:0] rgb;
    logic [4:0] stack_count;
    logic       stack_full;

    // Game logic and VGA timing drive the stream; they observe colour and stack status.
    modport master (
        output pos_x, pos_y, height, place, clear, hc, vc, video_on,
        input  rgb, stack_count, stack_full
    );

    // The renderer consumes positions and pixel coordinates and produces colour.
    modport slave (
        input  pos_x, pos_y, height, place, clear, hc, vc, video_on,
        output rgb, stack_count, stack_full
    );
endinterface

// File: rtl/stack_render.sv
// Records settled block x positions and paints the tower plus the moving block into the VGA stream.
// Latency: rgb follows hc/vc/video_on by 2 clocks; stack_count/stack_full update 1 clock after place/clear.
// Backpressure: none; place while full is dropped, and clear takes priority over place.
// Optional STACK_RENDER_OUTLINE_EN: paints block border pixels black instead of solid fill.
module stack_render #(
    parameter int         BLOCK_W      = 30,
    parameter int         BLOCK_H_LOG2 = 4,
    parameter int         MAX_BLOCKS   = 16,
    parameter int         BASE_Y       = 464,
    parameter logic [7:0] COLOR_EVEN   = 8'b111_000_00,
    parameter logic [7:0] COLOR_ODD    = 8'b000_111_00,
    parameter logic [7:0] COLOR_ACTIVE = 8'b111_111_00,
    parameter logic [7:0] COLOR_BG     = 8'b000_000_10
) (
    input  logic          clk,
    input  logic          rst,
    stack_render_if.slave bus
);
    localparam int         IW      = $clog2(MAX_BLOCKS);
    localparam logic [10:0] BW11    = 11'(BLOCK_W);
    localparam logic [10:0] BWM1    = 11'(BLOCK_W - 1);
    localparam logic [10:0] BH11    = 11'(1 << BLOCK_H_LOG2);
    localparam logic [10:0] BHM1    = 11'((1 << BLOCK_H_LOG2) - 1);
    localparam logic [10:0] BASE_M1 = 11'(BASE_Y - 1);
    localparam logic [4:0]  MAXC    = 5'(MAX_BLOCKS);

    // ---------------- history / count ----------------
    logic [4:0] count_q, count_d;
    logic       full_q, full_d;
    logic       do_write;
    logic [9:0] x_hist_q [MAX_BLOCKS];

    // Next count: clear beats place, and place is ignored once the stack is full.
    always_comb begin
        count_d  = count_q;
        do_write = 1'b0;
        if (bus.clear) begin
            count_d = 5'd0;
        end else if (bus.place && (count_q < MAXC)) begin
            count_d  = count_q + 5'd1;
            do_write = 1'b1;
        end
        full_d = (count_d == MAXC);
    end

    // Count and full flag registers; full tracks the count it is stored with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 5'd0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // History file needs no reset: rows at or above count are never drawn.
    always_ff @(posedge clk) begin
        if (do_write) begin
            x_hist_q[count_q[IW-1:0]] <= bus.pos_x;
        end
    end

    // ---------------- stage 1 ----------------
    logic [10:0]   hc11, vc11, px11, py11, dy;
    logic [IW-1:0] row_idx;
    logic [9:0]    hx_d;
    logic          in_tower_d, act_d;

    // Tower row lookup and active-block hit test, all in 11 bits so pos+size cannot wrap.
    always_comb begin
        hc11       = {1'b0, bus.hc};
        vc11       = {1'b0, bus.vc};
        px11       = {1'b0, bus.pos_x};
        py11       = {1'b0, bus.pos_y};
        dy         = BASE_M1 - vc11;
        row_idx    = dy[BLOCK_H_LOG2 +: IW];
        // dy < count*height is the same test as (dy >> log2 height) < count.
        in_tower_d = !dy[10] && (dy < (11'(count_q) << BLOCK_H_LOG2));
        hx_d       = x_hist_q[row_idx];
        act_d      = (bus.height != 10'd0) &&
                     (hc11 >= px11) && (hc11 < px11 + BW11) &&
                     (vc11 >= py11) && (vc11 < py11 + BH11);
    end

`ifdef STACK_RENDER_OUTLINE_EN
    logic act_edge_d, twr_edge_d, act_edge_q, twr_edge_q;

    // Border flags; settled-row vertical edges come from dy's position inside its row.
    always_comb begin
        act_edge_d = (hc11 == px11) || (hc11 == px11 + BWM1) ||
                     (vc11 == py11) || (vc11 == py11 + BHM1);
        twr_edge_d = (hc11 == {1'b0, hx_d}) || (hc11 == {1'b0, hx_d} + BWM1) ||
                     (dy[BLOCK_H_LOG2-1:0] == '0) || (dy[BLOCK_H_LOG2-1:0] == '1);
    end

    // Border flags travel with the rest of stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_edge_q <= 1'b0;
            twr_edge_q <= 1'b0;
        end else begin
            act_edge_q <= act_edge_d;
            twr_edge_q <= twr_edge_d;
        end
    end
`else
    logic unused_bhm1;
    assign unused_bhm1 = ^BHM1 ^ ^BWM1;
`endif

    logic       vo_q, act_q, tower_q, row0_q;
    logic [9:0] hc_q, hx_q;

    // Stage 1 registers; the row's x is fetched here so a later place cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vo_q    <= 1'b0;
            act_q   <= 1'b0;
            tower_q <= 1'b0;
            row0_q  <= 1'b0;
            hc_q    <= 10'd0;
            hx_q    <= 10'd0;
        end else begin
            vo_q    <= bus.video_on;
            act_q   <= act_d;
            tower_q <= in_tower_d;
            row0_q  <= row_idx[0];
            hc_q    <= bus.hc;
            hx_q    <= hx_d;
        end
    end

    // ---------------- stage 2 ----------------
    logic       in_x;
    logic [7:0] rgb_d, rgb_q;

    // Colour select: blanking, then active block, then settled row, then background.
    always_comb begin
        in_x  = ({1'b0, hc_q} >= {1'b0, hx_q}) && ({1'b0, hc_q} < {1'b0, hx_q} + BW11);
        rgb_d = COLOR_BG;
        if (!vo_q) begin
            rgb_d = 8'h00;
        end else if (act_q) begin
            rgb_d = COLOR_ACTIVE;
`ifdef STACK_RENDER_OUTLINE_EN
            if (act_edge_q) rgb_d = 8'h00;
`endif
        end else if (tower_q && in_x) begin
            rgb_d = row0_q ? COLOR_ODD : COLOR_EVEN;
`ifdef STACK_RENDER_OUTLINE_EN
            if (twr_edge_q) rgb_d = 8'h00;
`endif
        end
    end

    // Output colour register; async reset blanks the screen immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= 8'h00;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign bus.rgb         = rgb_q;
    assign bus.stack_count = count_q;
    assign bus.stack_full  = full_q;
endmodule

// File: tb/tb_stack_render.sv
// Directed bench for stack_render: reset, placing, active block, overflow, priority, clear.
// Latency: checks rgb two clocks after each pixel is presented.
// Backpressure: not applicable.
module tb_stack_render;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stack_render_if sr_if ();
    stack_render dut (.clk(clk), .rst(rst), .bus(sr_if));

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] C_EVEN = 8'hE0;
    localparam logic [7:0] C_ODD  = 8'h1C;
    localparam logic [7:0] C_ACT  = 8'hFC;
    localparam logic [7:0] C_BG   = 8'h02;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic [9:0] ht;
        logic [9:0] hc;
        logic [9:0] vc;
        logic       vo;
        logic [7:0] exp;
    } vec_t;

    vec_t vt [19];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Present one pixel and compare rgb two clocks later (called at posedge+1).
    task automatic px(input logic [9:0] h, input logic [9:0] v, input logic vo,
                      input logic [7:0] want, input string name);
        sr_if.hc       = h;
        sr_if.vc       = v;
        sr_if.video_on = vo;
        @(posedge clk);
        @(posedge clk);
        #1;
        check(name, 32'(sr_if.rgb), 32'(want));
    endtask

    task automatic do_place(input logic [9:0] x);
        sr_if.pos_x = x;
        sr_if.place = 1'b1;
        @(posedge clk);
        #1;
        sr_if.place = 1'b0;
    endtask

    task automatic do_clear();
        sr_if.clear = 1'b1;
        @(posedge clk);
        #1;
        sr_if.clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // x_hist[0]=305, count=1 for all of these
        vt[0]  = '{10'd305, 10'd0,   10'd0, 10'd310, 10'd455, 1'b1, C_EVEN};
        vt[1]  = '{10'd305, 10'd0,   10'd0, 10'd340, 10'd455, 1'b1, C_BG};
        vt[2]  = '{10'd305, 10'd0,   10'd0, 10'd334, 10'd455, 1'b1, C_EVEN};
        vt[3]  = '{10'd305, 10'd0,   10'd0, 10'd335, 10'd455, 1'b1, C_BG};
        vt[4]  = '{10'd305, 10'd0,   10'd0, 10'd304, 10'd455, 1'b1, C_BG};
        vt[5]  = '{10'd305, 10'd0,   10'd0, 10'd305, 10'd463, 1'b1, C_EVEN};
        vt[6]  = '{10'd305, 10'd0,   10'd0, 10'd305, 10'd464, 1'b1, C_BG};
        vt[7]  = '{10'd305, 10'd0,   10'd0, 10'd305, 10'd448, 1'b1, C_EVEN};
        vt[8]  = '{10'd305, 10'd0,   10'd0, 10'd305, 10'd447, 1'b1, C_BG};
        vt[9]  = '{10'd305, 10'd0,   10'd0, 10'd310, 10'd455, 1'b0, 8'h00};
        vt[10] = '{10'd305, 10'd360, 10'd1, 10'd305, 10'd360, 1'b1, C_ACT};
        vt[11] = '{10'd305, 10'd360, 10'd1, 10'd334, 10'd375, 1'b1, C_ACT};
        vt[12] = '{10'd305, 10'd360, 10'd1, 10'd335, 10'd360, 1'b1, C_BG};
        vt[13] = '{10'd305, 10'd360, 10'd1, 10'd305, 10'd376, 1'b1, C_BG};
        vt[14] = '{10'd305, 10'd360, 10'd1, 10'd305, 10'd359, 1'b1, C_BG};
        vt[15] = '{10'd305, 10'd360, 10'd0, 10'd305, 10'd360, 1'b1, C_BG};
        vt[16] = '{10'd305, 10'd450, 10'd1, 10'd310, 10'd455, 1'b1, C_ACT};
        vt[17] = '{10'd305, 10'd450, 10'd1, 10'd310, 10'd455, 1'b0, 8'h00};
        vt[18] = '{10'd305, 10'd450, 10'd1, 10'd310, 10'd440, 1'b1, C_BG};

        rst            = 1'b1;
        sr_if.pos_x    = '0;
        sr_if.pos_y    = '0;
        sr_if.height   = '0;
        sr_if.place    = 1'b0;
        sr_if.clear    = 1'b0;
        sr_if.hc       = '0;
        sr_if.vc       = '0;
        sr_if.video_on = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rgb",   32'(sr_if.rgb), 32'h0);
        check("reset_count", 32'(sr_if.stack_count), 32'd0);
        check("reset_full",  32'(sr_if.stack_full), 32'd0);

        // release with background pixel presented: black for one clock, background on the second
        sr_if.hc = 10'd100; sr_if.vc = 10'd100; sr_if.video_on = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("release_lat1", 32'(sr_if.rgb), 32'h0);
        @(posedge clk); #1;
        check("release_lat2", 32'(sr_if.rgb), 32'(C_BG));

        // mid-stream async reset
        do_place(10'd50);
        check("pre_rst_count", 32'(sr_if.stack_count), 32'd1);
        check("pre_rst_rgb",   32'(sr_if.rgb), 32'(C_BG));
        rst = 1'b1;
        #1;
        check("midrst_rgb",   32'(sr_if.rgb), 32'h0);
        check("midrst_count", 32'(sr_if.stack_count), 32'd0);
        check("midrst_full",  32'(sr_if.stack_full), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rerelease_lat1", 32'(sr_if.rgb), 32'h0);
        @(posedge clk); #1;
        check("rerelease_lat2", 32'(sr_if.rgb), 32'(C_BG));

        // single settled block plus active block table
        do_place(10'd305);
        check("single_count", 32'(sr_if.stack_count), 32'd1);
        check("single_full",  32'(sr_if.stack_full), 32'd0);
        for (int i = 0; i < 19; i++) begin
            sr_if.pos_x  = vt[i].px;
            sr_if.pos_y  = vt[i].py;
            sr_if.height = vt[i].ht;
            px(vt[i].hc, vt[i].vc, vt[i].vo, vt[i].exp, $sformatf("vec%0d", i));
        end
        sr_if.height = '0;

        // overflow: 17 places, the last one dropped
        do_clear();
        check("ovf_clear", 32'(sr_if.stack_count), 32'd0);
        for (int i = 0; i < 17; i++) begin
            do_place(10'(10 * i));
            if (i == 14) begin
                check("ovf_count15", 32'(sr_if.stack_count), 32'd15);
                check("ovf_full15",  32'(sr_if.stack_full), 32'd0);
            end
            if (i >= 15) begin
                check($sformatf("ovf_count_p%0d", i + 1), 32'(sr_if.stack_count), 32'd16);
                check($sformatf("ovf_full_p%0d", i + 1),  32'(sr_if.stack_full), 32'd1);
            end
        end
        px(10'd0,   10'd463, 1'b1, C_EVEN, "hist0_kept");
        px(10'd10,  10'd447, 1'b1, C_ODD,  "row1_odd");
        px(10'd150, 10'd208, 1'b1, C_ODD,  "row15_left");
        px(10'd179, 10'd208, 1'b1, C_ODD,  "row15_right");
        px(10'd180, 10'd208, 1'b1, C_BG,   "row15_past");
        px(10'd150, 10'd207, 1'b1, C_BG,   "row16_empty");

        // clear wins over a simultaneous place
        do_clear();
        do_place(10'd100);
        do_place(10'd200);
        do_place(10'd300);
        check("clr_count3", 32'(sr_if.stack_count), 32'd3);
        px(10'd200, 10'd447, 1'b1, C_ODD, "clr_pre_row1");
        sr_if.pos_x = 10'd400;
        sr_if.place = 1'b1;
        sr_if.clear = 1'b1;
        @(posedge clk); #1;
        sr_if.place = 1'b0;
        sr_if.clear = 1'b0;
        check("clr_count0", 32'(sr_if.stack_count), 32'd0);
        check("clr_full0",  32'(sr_if.stack_full), 32'd0);
        px(10'd100, 10'd463, 1'b1, C_BG, "clr_row0");
        px(10'd200, 10'd447, 1'b1, C_BG, "clr_row1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stack_render.md
Name: stack_render

Overview:
- Consumer (reader) side of the stack game's block-position interface.
- Latches each placed block's x position into a history register file when a place strobe fires.
- Draws the settled tower plus the moving active block (pos_x/pos_y/height) into the VGA pixel stream, producing 8-bit RGB.
- Sits between the stack game logic and the VGA sync/timing block.

Parameters:
- BLOCK_W, 30, block width in pixels.
- BLOCK_H_LOG2, 4, log2 of block height (block height = 16 px).
- MAX_BLOCKS, 16, history depth (rows); must be a power of two.
- BASE_Y, 464, first pixel row below the bottom of the tower.
- COLOR_EVEN, 8'b111_000_00, fill for settled rows with even index.
- COLOR_ODD, 8'b000_111_00, fill for settled rows with odd index.
- COLOR_ACTIVE, 8'b111_111_00, fill for the moving block.
- COLOR_BG, 8'b000_000_10, background while video is on.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- pos_x  in  10  left x of the active block.
- pos_y  in  10  top y of the active block.
- height  in  10  game height; active block drawn only when nonzero.
- place  in  1  one-cycle strobe: commit pos_x as the next settled row.
- clear  in  1  synchronous clear of the history.
- hc  in  10  current pixel column.
- vc  in  10  current pixel row.
- video_on  in  1  visible-region flag, aligned with hc/vc.
- rgb  out  8  pixel colour, RRRGGGBB.
- stack_count  out  5  number of settled rows, 0..MAX_BLOCKS.
- stack_full  out  1  high when stack_count == MAX_BLOCKS.

Behaviour:
- Reset (async, rst high):
  - stack_count=0, stack_full=0, rgb=0, all pipeline registers=0.
  - History contents: don't-care, but masked because count=0.
- History write:
  - On a clk edge with place=1, clear=0 and count<MAX_BLOCKS: x_hist[count] <= pos_x; count <= count+1.
  - Visible in stack_count the next cycle.
- place while full: ignored; count, history and stack_full unchanged.
- clear=1: count <= 0 next edge, regardless of place (clear wins).
- stack_full is registered, equal to (count == MAX_BLOCKS).
- Render pipeline, 2 cycles: rgb reflects the hc/vc/video_on sampled two edges earlier.
- Stage 1 registers hc, vc, video_on and computes:
  - dy = BASE_Y-1-vc, 11-bit signed.
  - row = dy >> BLOCK_H_LOG2.
  - in_tower = (dy >= 0) && (row < count).
  - act = (height != 0) && (hc >= pos_x) && (hc < pos_x+BLOCK_W) && (vc >= pos_y) && (vc < pos_y+2^BLOCK_H_LOG2).
  - All comparisons are 11-bit unsigned so pos_x+BLOCK_W cannot wrap.
- Stage 2 selects rgb by priority:
  1. !video_on -> 0.
  2. act -> COLOR_ACTIVE.
  3. in_tower && hc within [x_hist[row], x_hist[row]+BLOCK_W) -> COLOR_EVEN or COLOR_ODD by row[0].
  4. Otherwise COLOR_BG.
- History and count used by the render path are the values at the stage 1 edge. A place in the same cycle affects the next pixel only.
- Any nonzero pos_x is legal; blocks partly past column 639 are clipped naturally by video_on.
- Reset mid-frame: rgb=0 immediately (async); normal output resumes 2 cycles after rst falls.

Optional Feature:
- Macro: STACK_RENDER_OUTLINE_EN.
- Defined: any block pixel (active or settled) on the block's first/last column or first/last row renders as 8'b000_000_00. Same 2-cycle latency; edge detection is computed in stage 1.
- Undefined: blocks are solid fill; no outline logic is synthesized.

Test Plan:
- Reset: assert rst mid-stream -> rgb=0, stack_count=0, stack_full=0 within the same cycle; background 8'h02 at (100,100) with video_on=1 appears 2 cycles after release.
- Single place: pos_x=305, place pulse, then present hc=310, vc=455 -> stack_count=1, rgb=COLOR_EVEN 2 cycles later; hc=340 -> COLOR_BG; hc=334 -> COLOR_EVEN.
- Active block: pos_x=305, pos_y=360, height=1, hc=305, vc=360 -> COLOR_ACTIVE; height=0 -> COLOR_BG.
- Overflow: 17 place pulses with pos_x=10*i -> stack_count=16, stack_full=1; 17th ignored; row 15 (vc=BASE_Y-256) at hc=150 -> COLOR_ODD.
- Blanking and priority: active block overlapping settled row 0 -> COLOR_ACTIVE; same pixel with video_on=0 -> rgb=0.
- Clear: place and clear in the same cycle with count=3 -> stack_count=0 next cycle; tower pixels -> COLOR_BG.
